hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. Watches register indices and control bits in ID, EX, MEM and WB, and issues stall, bubble, flush and forwarding selects. The bubble output drives the `stall` input of the ID decode stage. A small FSM sequences load-use bubbles, data-memory wait freezes and branch redirects that arrive during a freeze; saturating counters expose stall and flush statistics.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared definitions for the 5-stage core hazard logic:
//               hazard FSM state encoding, EX operand forwarding selects and a
//               forwarding-select helper used for both EX operands.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Hazard FSM state encoding
    localparam int         c_state_w     = 2;
    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_lu_stall = 2'd1;
    localparam logic [1:0] c_st_mem_wait = 2'd2;

    // EX operand select encoding
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Operand source select for one EX operand. MEM is the younger producer,
    // so it wins over WB when both write the same register.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] src
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src))
            return FWD_MEM;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset, clears the count
//   i_inc    in   count one event this cycle
//   o_count  out  current count (CNT_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + c_one;
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage RISC-V core.
//               Issues PC / IF-ID / EX-MEM holds, ID bubbles, IF-ID / ID-EX
//               flushes, EX forwarding selects, ID write-through bypass, and
//               keeps saturating stall / flush statistics.
//   clk, rst_n                  clock, synchronous active-low reset
//   id_rs1/2, id_use_rs1/2      ID source registers and their use flags
//   ex_rd, ex_mem_read,
//   ex_reg_write                EX destination and control bits
//   mem_rd, mem_reg_write       MEM destination and write enable
//   wb_rd, wb_reg_write         WB destination and write enable
//   branch_taken                EX resolved a taken branch / JAL
//   dmem_busy                   data memory not ready this cycle
//   pc_hold, ifid_hold,
//   idex_bubble, exmem_hold     freeze / bubble controls
//   ifid_flush, idex_flush      pipeline register clears
//   fwd_a, fwd_b                EX operand selects
//   id_byp_rs1/2                ID register-file write-through selects
//   stall_cnt, flush_cnt        saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_rs1,
    output logic             id_byp_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic                 r_redir_pend;
    logic                 w_redir_pend_nxt;
    logic [4:0]           r_ex_rs1;
    logic [4:0]           r_ex_rs2;

    logic w_load_use;
    logic w_redirect;
    logic w_pc_hold;
    logic w_ifid_hold;
    logic w_idex_bubble;
    logic w_exmem_hold;
    logic w_flush;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    // EX never forwards its own result, so its write enable is not needed.
    logic w_unused;
    assign w_unused = ex_reg_write;

    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (ex_rd == id_rs1)) ||
                         (id_use_rs2 && (ex_rd == id_rs2)));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_run;
            r_redir_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_redir_pend <= w_redir_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs. dmem_busy beats a redirect, which
    // beats a load-use, whatever the current state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_redir_pend_nxt = r_redir_pend;
        w_redirect       = 1'b0;
        w_pc_hold        = 1'b0;
        w_ifid_hold      = 1'b0;
        w_idex_bubble    = 1'b0;
        w_exmem_hold     = 1'b0;
        w_flush          = 1'b0;

        if (dmem_busy) begin
            // Freeze; a branch resolved now is replayed once memory is ready.
            w_pc_hold    = 1'b1;
            w_ifid_hold  = 1'b1;
            w_exmem_hold = 1'b1;
            w_state_nxt  = c_st_mem_wait;
            if (branch_taken)
                w_redir_pend_nxt = 1'b1;
        end else begin
            case (r_state)
                c_st_mem_wait: begin
                    w_redirect       = r_redir_pend || branch_taken;
                    w_redir_pend_nxt = 1'b0;
                end
                default: begin
                    w_redirect = branch_taken;
                end
            endcase

            w_state_nxt = c_st_run;
            if (w_redirect) begin
                w_flush = 1'b1;
            end else if ((r_state != c_st_lu_stall) && w_load_use) begin
                // The cycle leaving MEM_WAIT behaves like RUN, so a load-use
                // still present there is stalled as well.
                w_pc_hold     = 1'b1;
                w_ifid_hold   = 1'b1;
                w_idex_bubble = 1'b1;
                w_state_nxt   = c_st_lu_stall;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX-stage copies of the source register indices
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_rs1 <= 5'd0;
            r_ex_rs2 <= 5'd0;
        end else if (w_idex_bubble || w_flush) begin
            r_ex_rs1 <= 5'd0;
            r_ex_rs2 <= 5'd0;
        end else if (!w_ifid_hold && !w_exmem_hold) begin
            r_ex_rs1 <= id_rs1;
            r_ex_rs2 <= id_rs2;
        end
    end

    assign w_fwd_a = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, r_ex_rs1);
    assign w_fwd_b = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, r_ex_rs2);

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_pc_hold),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_flush),
        .o_count (w_flush_cnt)
    );

    // ------------------------------------------------------------------
    // Outputs are quiet for as long as reset is held.
    // ------------------------------------------------------------------
    assign pc_hold     = rst_n & w_pc_hold;
    assign ifid_hold   = rst_n & w_ifid_hold;
    assign idex_bubble = rst_n & w_idex_bubble;
    assign exmem_hold  = rst_n & w_exmem_hold;
    assign ifid_flush  = rst_n & w_flush;
    assign idex_flush  = rst_n & w_flush;
    assign fwd_a       = rst_n ? w_fwd_a : FWD_RF;
    assign fwd_b       = rst_n ? w_fwd_b : FWD_RF;
    assign id_byp_rs1  = rst_n & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == id_rs1);
    assign id_byp_rs2  = rst_n & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == id_rs2);
    assign stall_cnt   = rst_n ? w_stall_cnt : '0;
    assign flush_cnt   = rst_n ? w_flush_cnt : '0;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed scenarios with
//               literal expectations, then randomized traffic; every cycle
//               both a 16-bit and a 4-bit counter instance are compared
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
    logic       mem_reg_write, wb_reg_write, branch_taken, dmem_busy;

    logic        pc_hold, ifid_hold, idex_bubble, exmem_hold, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        id_byp_rs1, id_byp_rs2;
    logic [15:0] stall_cnt, flush_cnt;

    logic        pc_hold_4, ifid_hold_4, idex_bubble_4, exmem_hold_4, ifid_flush_4, idex_flush_4;
    logic [1:0]  fwd_a_4, fwd_b_4;
    logic        id_byp_rs1_4, id_byp_rs2_4;
    logic [3:0]  stall_cnt_4, flush_cnt_4;

    hazard_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_rs1(id_byp_rs1), .id_byp_rs2(id_byp_rs2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_hold(pc_hold_4), .ifid_hold(ifid_hold_4), .idex_bubble(idex_bubble_4),
        .exmem_hold(exmem_hold_4), .ifid_flush(ifid_flush_4), .idex_flush(idex_flush_4),
        .fwd_a(fwd_a_4), .fwd_b(fwd_b_4), .id_byp_rs1(id_byp_rs1_4), .id_byp_rs2(id_byp_rs2_4),
        .stall_cnt(stall_cnt_4), .flush_cnt(flush_cnt_4)
    );

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what happened in the previous cycle decides what
    // is allowed now.
    //   prev_busy : memory stalled last cycle (we are waiting on it)
    //   prev_lu   : a load-use bubble was inserted last cycle
    //   pend      : a taken branch arrived while memory was stalled
    // ------------------------------------------------------------------
    bit         m_prev_busy, m_prev_lu, m_pend;
    logic [4:0] m_rs1, m_rs2;
    int         m_stall, m_flush;

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int w);
        int top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    always @(negedge clk) begin : p_compare
        bit e_lu, e_redir, e_hold, e_bub, e_xh, e_fl, e_b1, e_b2;
        logic [1:0] e_fa, e_fb;
        int e_s, e_f, e_s4, e_f4;
        if (cmp_en) begin
            n_vec++;
            e_redir = !dmem_busy && (branch_taken || m_pend);
            e_lu    = !dmem_busy && !e_redir && !m_prev_lu && ex_mem_read && ex_rd != 0 &&
                      ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
            e_hold  = dmem_busy || e_lu;
            e_bub   = e_lu;
            e_xh    = dmem_busy;
            e_fl    = e_redir;
            e_fa    = exp_fwd(m_rs1);
            e_fb    = exp_fwd(m_rs2);
            e_b1    = wb_reg_write && wb_rd != 0 && wb_rd == id_rs1;
            e_b2    = wb_reg_write && wb_rd != 0 && wb_rd == id_rs2;
            e_s     = sat(m_stall, 16);
            e_f     = sat(m_flush, 16);
            e_s4    = sat(m_stall, 4);
            e_f4    = sat(m_flush, 4);
            if (!rst_n) begin
                {e_hold, e_bub, e_xh, e_fl, e_b1, e_b2} = '0;
                e_fa = 2'b00; e_fb = 2'b00;
                e_s = 0; e_f = 0; e_s4 = 0; e_f4 = 0;
            end
            chk("pc_hold",     pc_hold,     e_hold);
            chk("ifid_hold",   ifid_hold,   e_hold);
            chk("idex_bubble", idex_bubble, e_bub);
            chk("exmem_hold",  exmem_hold,  e_xh);
            chk("ifid_flush",  ifid_flush,  e_fl);
            chk("idex_flush",  idex_flush,  e_fl);
            chk("fwd_a",       fwd_a,       e_fa);
            chk("fwd_b",       fwd_b,       e_fb);
            chk("id_byp_rs1",  id_byp_rs1,  e_b1);
            chk("id_byp_rs2",  id_byp_rs2,  e_b2);
            chk("stall_cnt",   stall_cnt,   e_s);
            chk("flush_cnt",   flush_cnt,   e_f);
            chk("pc_hold_4",   pc_hold_4,   e_hold);
            chk("ifid_flush_4", ifid_flush_4, e_fl);
            chk("fwd_a_4",     fwd_a_4,     e_fa);
            chk("stall_cnt_4", stall_cnt_4, e_s4);
            chk("flush_cnt_4", flush_cnt_4, e_f4);

            // Advance the model to the state after the coming edge.
            if (!rst_n) begin
                m_prev_busy = 0; m_prev_lu = 0; m_pend = 0;
                m_rs1 = 0; m_rs2 = 0; m_stall = 0; m_flush = 0;
            end else begin
                if (e_lu || e_fl) begin
                    m_rs1 = 0; m_rs2 = 0;
                end else if (!e_hold) begin
                    m_rs1 = id_rs1; m_rs2 = id_rs2;
                end
                m_pend      = dmem_busy ? (m_pend || branch_taken) : 1'b0;
                m_prev_busy = dmem_busy;
                m_prev_lu   = e_lu;
                m_stall     = m_stall + (e_hold ? 1 : 0);
                m_flush     = m_flush + (e_fl ? 1 : 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
        branch_taken = 0; dmem_busy = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        m_prev_busy = 0; m_prev_lu = 0; m_pend = 0;
        m_rs1 = 0; m_rs2 = 0; m_stall = 0; m_flush = 0;
        cmp_en = 1;
        step(); step();
        #1;
        chk("rst_pc_hold",   pc_hold,   0);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst_n = 1;

        // Load-use: lw x5 in EX, ID reads x5
        ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        chk("lu_pc_hold",   pc_hold,     1);
        chk("lu_ifid_hold", ifid_hold,   1);
        chk("lu_bubble",    idex_bubble, 1);
        step();
        ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0; mem_rd = 5; mem_reg_write = 1;
        #1;
        chk("lu_next_hold", pc_hold, 0);
        step();
        #1;
        chk("lu_fwd_a",     fwd_a,     2'b10);
        chk("lu_stall_cnt", stall_cnt, 1);

        // Taken branch with a load-use also present
        do_reset();
        ex_rd = 5; ex_mem_read = 1; id_rs1 = 5; id_use_rs1 = 1; branch_taken = 1;
        #1;
        chk("br_ifid_flush", ifid_flush,  1);
        chk("br_idex_flush", idex_flush,  1);
        chk("br_bubble",     idex_bubble, 0);
        step();
        idle();
        #1;
        chk("br_flush_cnt", flush_cnt, 1);

        // dmem_busy for 3 cycles, branch in the first one
        do_reset();
        dmem_busy = 1; branch_taken = 1;
        #1;
        chk("mw_hold1", exmem_hold, 1);
        chk("mw_flush1", ifid_flush, 0);
        step();
        branch_taken = 0;
        #1;
        chk("mw_hold2", pc_hold, 1);
        chk("mw_flush2", idex_flush, 0);
        step();
        #1;
        chk("mw_hold3", ifid_hold, 1);
        step();
        dmem_busy = 0;
        #1;
        chk("mw_flush4", ifid_flush, 1);
        chk("mw_hold4",  pc_hold,    0);
        step();
        #1;
        chk("mw_stall_cnt", stall_cnt, 3);
        chk("mw_flush_cnt", flush_cnt, 1);

        // Write-through bypass
        idle();
        wb_rd = 7; wb_reg_write = 1; id_rs2 = 7;
        #1;
        chk("byp_rs2_x7", id_byp_rs2, 1);
        wb_rd = 0; id_rs2 = 0;
        #1;
        chk("byp_rs2_x0", id_byp_rs2, 0);

        // MEM beats WB
        idle();
        id_rs1 = 3;
        step();
        id_rs1 = 0; mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
        #1;
        chk("fwd_mem_prio", fwd_a, 2'b10);

        // Reset in MEM_WAIT with a redirect pending
        do_reset();
        dmem_busy = 1; branch_taken = 1;
        step();
        branch_taken = 0;
        step();
        rst_n = 0; branch_taken = 1;
        #1;
        chk("rstmw_pc_hold", pc_hold,    0);
        chk("rstmw_exmem",   exmem_hold, 0);
        step();
        rst_n = 1; dmem_busy = 0; branch_taken = 0;
        #1;
        chk("rstmw_flush",     ifid_flush, 0);
        chk("rstmw_stall_cnt", stall_cnt,  0);
        chk("rstmw_flush_cnt", flush_cnt,  0);

        // Saturation of the 4-bit counter
        dmem_busy = 1;
        repeat (20) step();
        dmem_busy = 0;
        #1;
        chk("sat_stall_cnt4",  stall_cnt_4, 15);
        chk("sat_stall_cnt16", stall_cnt,   20);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n         = ($urandom_range(0, 63) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            ex_rd         = 5'($urandom_range(0, 3));
            ex_mem_read   = 1'($urandom_range(0, 1));
            ex_reg_write  = 1'($urandom_range(0, 1));
            mem_rd        = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_rd         = 5'($urandom_range(0, 3));
            wb_reg_write  = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 4) == 0);
            dmem_busy     = ($urandom_range(0, 3) == 0);
        end
        step();
        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
